serdes_rx_block_align: RTL and testbench

Parametrised next-generation RX deserializer. It adds sync-header-based block alignment: bit-slip hunting, a lock/unlock state machine with a windowed error budget, and an enable/stall input. It sits between the channel serial input and the PCS, and emits aligned P_WIDTH-bit blocks with a valid strobe once block lock is achieved.

---
 rtl/serdes_rx_pkg.sv | 17 +
 rtl/serdes_blk_lock_fsm.sv | 112 +++++++++++
 rtl/serdes_rx_block_align.sv | 124 ++++++++++++
 tb/tb_serdes_rx_block_align.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_rx_pkg.sv
// Shared types and header helpers for the RX block aligner.
package serdes_rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TENT   = 2'd1,
        LOCKED = 2'd2
    } blk_state_t;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_OSET = 2'b01;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_OSET);
    endfunction

endpackage

// File: rtl/serdes_blk_lock_fsm.sv
// Block-lock state machine: hunts for valid sync headers, declares lock,
// and drops lock when too many bad headers land in one window.
module serdes_blk_lock_fsm
    import serdes_rx_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_BAD = 4,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned GOOD_W     = $clog2(LOCK_CNT + 1),
    parameter int unsigned BAD_W      = $clog2(UNLOCK_BAD + 1),
    parameter int unsigned BLK_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boundary,
    input  logic              hdr_ok,
    output blk_state_t        state,
    output blk_state_t        state_nxt_c,
    output logic              slip_c,
    output logic              lock_lost_c,
    output logic [GOOD_W-1:0] good,
    output logic [BAD_W-1:0]  bad,
    output logic [BLK_W-1:0]  blk
);

    logic [GOOD_W-1:0] good_nxt;
    logic [BAD_W-1:0]  bad_nxt;
    logic [BLK_W-1:0]  blk_nxt;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_sum;

    assign good_inc = good + GOOD_W'(1);
    // bad never exceeds UNLOCK_BAD-1 while locked, so the sum cannot wrap
    assign bad_sum  = bad + BAD_W'(!hdr_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            good  <= '0;
            bad   <= '0;
            blk   <= '0;
        end else begin
            state <= state_nxt_c;
            good  <= good_nxt;
            bad   <= bad_nxt;
            blk   <= blk_nxt;
        end
    end

    always_comb begin
        state_nxt_c = state;
        good_nxt    = good;
        bad_nxt     = bad;
        blk_nxt     = blk;
        if (boundary) begin
            unique case (state)
                HUNT: begin
                    if (hdr_ok) begin
                        good_nxt = GOOD_W'(1);
                        if (LOCK_CNT == 1) begin
                            state_nxt_c = LOCKED;
                            bad_nxt     = '0;
                            blk_nxt     = '0;
                        end else begin
                            state_nxt_c = TENT;
                        end
                    end
                end
                TENT: begin
                    if (hdr_ok) begin
                        good_nxt = good_inc;
                        if (32'(good_inc) == LOCK_CNT) begin
                            state_nxt_c = LOCKED;
                            bad_nxt     = '0;
                            blk_nxt     = '0;
                        end
                    end else begin
                        state_nxt_c = HUNT;
                        good_nxt    = '0;
                    end
                end
                LOCKED: begin
                    if (32'(bad_sum) == UNLOCK_BAD) begin
                        state_nxt_c = HUNT;
                        good_nxt    = '0;
                    end else if (32'(blk) == WINDOW - 1) begin
                        blk_nxt = '0;
                        bad_nxt = '0;
                    end else begin
                        blk_nxt = blk + BLK_W'(1);
                        bad_nxt = bad_sum;
                    end
                end
                default: state_nxt_c = HUNT;
            endcase
        end
    end

    always_comb begin
        slip_c      = 1'b0;
        lock_lost_c = 1'b0;
        if (boundary) begin
            if (state == LOCKED) begin
                lock_lost_c = (32'(bad_sum) == UNLOCK_BAD);
                slip_c      = lock_lost_c;
            end else begin
                slip_c = !hdr_ok;
            end
        end
    end

endmodule

// File: rtl/serdes_rx_block_align.sv
// Serial-to-parallel RX with sync-header block alignment, bit-slip hunting
// and a windowed loss-of-lock error budget.
module serdes_rx_block_align
    import serdes_rx_pkg::*;
#(
    parameter int unsigned P_WIDTH    = 130,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_BAD = 4,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned ERR_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               serial_in,
    input  logic               rx_en,
    input  logic               err_clr,
    output logic [P_WIDTH-1:0] parallel_out,
    output logic               out_valid,
    output logic [1:0]         sync_hdr,
    output logic               block_lock,
    output logic               hdr_err,
    output logic               slip,
    output logic               lock_lost,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int unsigned CNT_W  = $clog2(P_WIDTH);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_BAD + 1);
    localparam int unsigned BLK_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [P_WIDTH-2:0] sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [P_WIDTH-1:0] word_c;
    logic [1:0]         hdr_c;
    logic               boundary_c;
    logic               hdr_ok_c;
    logic               err_inc_c;

    blk_state_t         state;
    blk_state_t         state_nxt_c;
    logic               slip_c;
    logic               lock_lost_c;
    logic [GOOD_W-1:0]  good;
    logic [BAD_W-1:0]   bad;
    logic [BLK_W-1:0]   blk;

    assign word_c     = {sr, serial_in};
    assign hdr_c      = word_c[P_WIDTH-1 -: 2];
    assign boundary_c = rx_en && (32'(bit_cnt) == P_WIDTH - 1);
    assign hdr_ok_c   = hdr_valid(hdr_c);
    assign err_inc_c  = boundary_c && (state == LOCKED) && !hdr_ok_c;

    serdes_blk_lock_fsm #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_BAD (UNLOCK_BAD),
        .WINDOW     (WINDOW)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .boundary    (boundary_c),
        .hdr_ok      (hdr_ok_c),
        .state       (state),
        .state_nxt_c (state_nxt_c),
        .slip_c      (slip_c),
        .lock_lost_c (lock_lost_c),
        .good        (good),
        .bad         (bad),
        .blk         (blk)
    );

    // Shift register and bit counter; a slip shortens the next block by one bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (rx_en) begin
            sr <= word_c[P_WIDTH-2:0];
            if (boundary_c) begin
                bit_cnt <= slip_c ? CNT_W'(1) : '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_out <= '0;
            sync_hdr     <= '0;
            out_valid    <= 1'b0;
            block_lock   <= 1'b0;
            hdr_err      <= 1'b0;
            slip         <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            out_valid  <= boundary_c && (state_nxt_c == LOCKED);
            block_lock <= (state_nxt_c == LOCKED);
            hdr_err    <= boundary_c && !hdr_ok_c;
            slip       <= slip_c;
            lock_lost  <= lock_lost_c;
            if (boundary_c) begin
                parallel_out <= word_c;
                sync_hdr     <= hdr_c;
            end
        end
    end

    // Saturating error counter; a clear coinciding with an increment leaves 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= ERR_W'(err_inc_c);
        end else if (err_inc_c && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    assert property (@(posedge clk) disable iff (rst) 32'(good) <= LOCK_CNT);
    assert property (@(posedge clk) disable iff (rst) 32'(bad) < UNLOCK_BAD);
    assert property (@(posedge clk) disable iff (rst) 32'(blk) < WINDOW);

endmodule

// File: tb/tb_serdes_rx_block_align.sv
// Bench for serdes_rx_block_align: bit-history model plus directed scenarios.
module tb_serdes_rx_block_align;

    localparam int P          = 130;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_BAD = 4;
    localparam int WINDOW     = 64;
    localparam int ERR_W      = 16;

    logic           clk;
    logic           rst;
    logic           serial_in;
    logic           rx_en;
    logic           err_clr;
    logic [P-1:0]   parallel_out;
    logic           out_valid;
    logic [1:0]     sync_hdr;
    logic           block_lock;
    logic           hdr_err;
    logic           slip;
    logic           lock_lost;
    logic [ERR_W-1:0] err_cnt;

    serdes_rx_block_align #(
        .P_WIDTH    (P),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_BAD (UNLOCK_BAD),
        .WINDOW     (WINDOW),
        .ERR_W      (ERR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .rx_en        (rx_en),
        .err_clr      (err_clr),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .sync_hdr     (sync_hdr),
        .block_lock   (block_lock),
        .hdr_err      (hdr_err),
        .slip         (slip),
        .lock_lost    (lock_lost),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int n_slip = 0;
    int n_herr = 0;

    task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: all received bits kept as a history; block ends counted in bits
    bit             hist[$];
    int             nbits;
    int             next_b;
    bit             m_locked;
    int             m_run;
    int             m_win_pos;
    int             m_win_bad;
    logic [P-1:0]   e_po;
    logic [1:0]     e_hdr;
    logic           e_valid, e_lock, e_herr, e_slip, e_lost;
    logic [ERR_W-1:0] e_err;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < P; i++) hist.push_back(1'b0);
        nbits = 0; next_b = P;
        m_locked = 0; m_run = 0; m_win_pos = 0; m_win_bad = 0;
        e_po = '0; e_hdr = '0; e_valid = 0; e_lock = 0;
        e_herr = 0; e_slip = 0; e_lost = 0; e_err = '0;
    endtask

    task automatic model_step();
        bit ok, inc, slipped;
        e_herr = 0; e_slip = 0; e_lost = 0; e_valid = 0;
        inc = 0; slipped = 0;
        if (rx_en) begin
            hist.push_back(serial_in);
            void'(hist.pop_front());
            nbits++;
            if (nbits == next_b) begin
                for (int i = 0; i < P; i++) e_po[P-1-i] = hist[i];
                e_hdr = e_po[P-1:P-2];
                ok = (e_hdr == 2'b01) || (e_hdr == 2'b10);
                e_herr = !ok;
                inc = m_locked && !ok;
                if (!m_locked) begin
                    if (ok) begin
                        m_run++;
                        if (m_run == LOCK_CNT) begin
                            m_locked = 1; m_win_pos = 0; m_win_bad = 0;
                        end
                    end else begin
                        m_run = 0; slipped = 1;
                    end
                end else begin
                    if (!ok) m_win_bad++;
                    if (m_win_bad == UNLOCK_BAD) begin
                        m_locked = 0; m_run = 0; slipped = 1; e_lost = 1;
                    end else if (m_win_pos == WINDOW - 1) begin
                        m_win_pos = 0; m_win_bad = 0;
                    end else begin
                        m_win_pos++;
                    end
                end
                e_slip = slipped;
                e_valid = m_locked;
                next_b += slipped ? P - 1 : P;
            end
        end
        if (err_clr) e_err = ERR_W'(inc);
        else if (inc && e_err != {ERR_W{1'b1}}) e_err = e_err + ERR_W'(1);
        e_lock = m_locked;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("parallel_out", parallel_out, e_po);
            check("sync_hdr", P'(sync_hdr), P'(e_hdr));
            check("out_valid", P'(out_valid), P'(e_valid));
            check("block_lock", P'(block_lock), P'(e_lock));
            check("hdr_err", P'(hdr_err), P'(e_herr));
            check("slip", P'(slip), P'(e_slip));
            check("lock_lost", P'(lock_lost), P'(e_lost));
            check("err_cnt", P'(err_cnt), P'(e_err));
            if (slip === 1'b1) n_slip++;
            if (hdr_err === 1'b1) n_herr++;
        end
    end

    task automatic send_bit(input logic b, input logic en, input logic clr);
        serial_in = b; rx_en = en; err_clr = clr;
        @(posedge clk); #1;
    endtask

    task automatic send_range(input logic [P-1:0] blk, input int hi, input int lo, input logic clr_last);
        for (int i = hi; i >= lo; i--) send_bit(blk[i], 1'b1, clr_last && (i == lo));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        serial_in = 0; rx_en = 0; err_clr = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    function automatic logic [P-1:0] mk_blk(input logic [1:0] h);
        logic [P-3:0] pl;
        pl = {$urandom(), $urandom(), $urandom(), $urandom()};
        return {h, pl};
    endfunction

    logic [P-1:0] b;
    logic [P-1:0] zb;

    initial begin
        rst = 0; serial_in = 0; rx_en = 0; err_clr = 0;
        zb = {2'b10, {(P-2){1'b0}}};
        #2;
        do_reset();
        chk_en = 1;
        check("reset parallel_out", parallel_out, '0);
        check("reset block_lock", P'(block_lock), P'(1'b0));

        // Aligned random stream: lock visible after the 4th block (cycle 520)
        for (int k = 0; k < 3; k++) begin
            b = mk_blk(2'b10);
            send_range(b, P-1, 0, 1'b0);
        end
        b = mk_blk(2'b10);
        send_range(b, P-1, 1, 1'b0);
        check("t1 lock before 4th", P'(block_lock), P'(1'b0));
        send_range(b, 0, 0, 1'b0);
        check("t1 block_lock", P'(block_lock), P'(1'b1));
        check("t1 out_valid", P'(out_valid), P'(1'b1));
        check("t1 parallel_out", parallel_out, b);
        check("t1 no slip", P'(slip), P'(1'b0));

        // Stall 50 cycles mid-block: output delayed by exactly 50 cycles
        b = mk_blk(2'b01);
        send_range(b, P-1, 70, 1'b0);
        check("t5 pulse ended", P'(out_valid), P'(1'b0));
        idle(50);
        send_range(b, 69, 50, 1'b0);
        check("t5 no early valid", P'(out_valid), P'(1'b0));
        send_range(b, 49, 1, 1'b0);
        check("t5 still no valid", P'(out_valid), P'(1'b0));
        send_range(b, 0, 0, 1'b0);
        check("t5 out_valid", P'(out_valid), P'(1'b1));
        check("t5 parallel_out", parallel_out, b);
        check("t5 hdr_err", P'(hdr_err), P'(1'b0));
        check("t5 block_lock", P'(block_lock), P'(1'b1));

        // Four bad headers in one window: lock is lost on the fourth
        n_herr = 0;
        for (int k = 0; k < 3; k++) begin
            b = mk_blk(2'b11);
            send_range(b, P-1, 0, 1'b0);
        end
        check("t3 lock held", P'(block_lock), P'(1'b1));
        check("t3 err_cnt 3", P'(err_cnt), P'(16'd3));
        b = mk_blk(2'b11);
        send_range(b, P-1, 0, 1'b0);
        check("t3 lock_lost", P'(lock_lost), P'(1'b1));
        check("t3 slip", P'(slip), P'(1'b1));
        check("t3 block_lock", P'(block_lock), P'(1'b0));
        check("t3 err_cnt 4", P'(err_cnt), P'(16'd4));
        idle(1);
        check("t3 hdr_err count", P'(n_herr), P'(4));
        check("t3 pulse ended", P'(lock_lost), P'(1'b0));

        // Stream one bit early: first header 00, one slip, then lock
        do_reset();
        n_slip = 0;
        send_range(zb, P-2, 0, 1'b0);
        send_range(zb, P-1, P-1, 1'b0);
        check("t2 slip at 130", P'(slip), P'(1'b1));
        check("t2 hdr_err at 130", P'(hdr_err), P'(1'b1));
        send_range(zb, P-2, 0, 1'b0);
        check("t2 next B valid", P'(hdr_err), P'(1'b0));
        check("t2 next B no slip", P'(slip), P'(1'b0));
        for (int k = 0; k < 3; k++) send_range(zb, P-1, 0, 1'b0);
        check("t2 block_lock", P'(block_lock), P'(1'b1));
        check("t2 parallel_out", parallel_out, zb);
        idle(1);
        check("t2 slip count", P'(n_slip), P'(1));

        // Bad headers spread over two windows keep lock; clear with increment gives 1
        b = {2'b11, {(P-2){1'b0}}};
        for (int k = 0; k < 3; k++) send_range(b, P-1, 0, 1'b0);
        for (int k = 0; k < WINDOW - 3; k++) send_range(zb, P-1, 0, 1'b0);
        for (int k = 0; k < 3; k++) send_range(b, P-1, 0, 1'b0);
        check("t4 lock held", P'(block_lock), P'(1'b1));
        check("t4 err_cnt 6", P'(err_cnt), P'(16'd6));
        send_range(b, P-1, 1, 1'b0);
        send_range(b, 0, 0, 1'b1);
        check("t4 err_cnt clr+inc", P'(err_cnt), P'(16'd1));
        send_bit(1'b0, 1'b0, 1'b1);
        check("t4 err_cnt clr", P'(err_cnt), P'(16'd0));

        // Reset mid-block while locked, then relock needs 4 aligned blocks
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b = mk_blk(2'b10);
            send_range(b, P-1, 0, 1'b0);
        end
        check("t6 locked", P'(block_lock), P'(1'b1));
        b = mk_blk(2'b10);
        send_range(b, P-1, 70, 1'b0);
        rst = 1;
        #1;
        check("t6 rst block_lock", P'(block_lock), P'(1'b0));
        check("t6 rst parallel_out", parallel_out, '0);
        check("t6 rst sync_hdr", P'(sync_hdr), P'(2'b00));
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < 3; k++) begin
            b = mk_blk(2'b10);
            send_range(b, P-1, 0, 1'b0);
        end
        b = mk_blk(2'b01);
        send_range(b, P-1, 1, 1'b0);
        check("t6 not yet relocked", P'(block_lock), P'(1'b0));
        send_range(b, 0, 0, 1'b0);
        check("t6 relocked", P'(block_lock), P'(1'b1));
        check("t6 out_valid", P'(out_valid), P'(1'b1));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
